// File: rtl/hazard_detection_unit.sv
// hazard_detection_unit: stall/flush control for load-use, ID-stage branch operands
// and data-memory wait states, with a memory-wait watchdog and saturating counters.
module hazard_detection_unit #(
   parameter int TIMEOUT = 16,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [4:0]      ifidrs,
   input  logic [4:0]      ifidrt,
   input  logic            ifidmemwr,
   input  logic            ifidbranch,
   input  logic            branchtaken,
   input  logic            idexmemrd,
   input  logic [4:0]      idexrt,
   input  logic            idexregwr,
   input  logic [4:0]      idexregmuxout,
   input  logic            exmemmemrd,
   input  logic [4:0]      exmemregmuxout,
   input  logic            memreq,
   input  logic            memready,
   input  logic            cntclr,
   output logic            pcwr,
   output logic            ifidwr,
   output logic            ifidflush,
   output logic            idexbubble,
   output logic            pipewr,
   output logic            memerror,
   output logic [1:0]      state,
   output logic [CNTW-1:0] stallcount,
   output logic [CNTW-1:0] freezecount,
   output logic [CNTW-1:0] flushcount
);
   localparam int WW = $clog2(TIMEOUT + 1);
   typedef enum logic [1:0] {RUN = 2'b00, MEMWAIT = 2'b01, ERROR = 2'b10} state_t;
   state_t cur, nxt;
   logic [WW-1:0] waitcnt, waitnxt;
   logic loaduse, brhaz, freeze, stall, halt;

   function automatic logic hit(input logic [4:0] r, input logic [4:0] rs, input logic [4:0] rt);
      return r != 5'd0 && (r == rs || r == rt);
   endfunction

   function automatic logic [CNTW-1:0] sat(input logic [CNTW-1:0] c, input logic en);
      return (en && !(&c)) ? c + 1'b1 : c;
   endfunction

   // sw rt is forwarded from MEM/WB, so it does not need a load-use stall
   assign loaduse = idexmemrd && idexrt != 5'd0 &&
                    (idexrt == ifidrs || (idexrt == ifidrt && !ifidmemwr));
   assign brhaz = ifidbranch && ((idexregwr && hit(idexregmuxout, ifidrs, ifidrt)) ||
                                 (idexmemrd && hit(idexrt, ifidrs, ifidrt)) ||
                                 (exmemmemrd && hit(exmemregmuxout, ifidrs, ifidrt)));
   assign freeze = memreq && !memready;
   assign stall = (loaduse || brhaz) && !freeze;
   assign halt = cur == ERROR || freeze;
   assign pcwr = !halt && !stall;
   assign ifidwr = !halt && !stall;
   assign pipewr = !halt;
   assign idexbubble = !halt && stall;
   assign ifidflush = !halt && !stall && ifidbranch && branchtaken;
   assign state = cur;

   always_comb begin
      nxt = cur;
      waitnxt = waitcnt;
      if (cur == RUN && freeze) begin
         nxt = MEMWAIT;
         waitnxt = WW'(1);
      end else if (cur == MEMWAIT) begin
         if (!freeze) begin
            nxt = RUN;
            waitnxt = '0;
         end else if (waitcnt == WW'(TIMEOUT - 1)) begin
            nxt = ERROR;
         end else begin
            waitnxt = waitcnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur <= RUN;
         waitcnt <= '0;
         memerror <= 1'b0;
         stallcount <= '0;
         freezecount <= '0;
         flushcount <= '0;
      end else begin
         cur <= nxt;
         waitcnt <= waitnxt;
         memerror <= memerror || nxt == ERROR;
         stallcount <= cntclr ? '0 : sat(stallcount, stall);
         freezecount <= cntclr ? '0 : sat(freezecount, freeze && cur != ERROR);
         flushcount <= cntclr ? '0 : sat(flushcount, ifidflush);
      end
   end
endmodule

// File: doc/hazard_detection_unit.md
Name: hazard_detection_unit

Overview:
- Stall/flush controller for the 5-stage semiMIPS pipeline; the producer-side complement to the forwarding unit.
- It handles every RAW hazard that forwarding cannot cover:
  - load-use on ALU operands;
  - branch operands compared in ID;
  - data-memory wait states.
- Drives PC and pipeline-register write enables, the ID/EX bubble and the IF/ID flush.
- Contains a memory-wait watchdog FSM and saturating stall/freeze/flush performance counters.

Parameters:
- TIMEOUT, 16: maximum consecutive memory-wait cycles before error (≥2).
- CNTW, 16: width of each performance counter.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- ifidrs  input  5  rs field of instruction in ID
- ifidrt  input  5  rt field of instruction in ID
- ifidmemwr  input  1  ID instruction is sw
- ifidbranch  input  1  ID instruction is beq/bne; compares registers in ID
- branchtaken  input  1  ID branch resolved taken
- idexmemrd  input  1  EX instruction is lw
- idexrt  input  5  destination of lw in EX
- idexregwr  input  1  EX instruction writes a register
- idexregmuxout  input  5  EX destination register
- exmemmemrd  input  1  MEM instruction is lw
- exmemregmuxout  input  5  MEM destination register
- memreq  input  1  MEM stage accessing data memory
- memready  input  1  data memory completes this cycle
- cntclr  input  1  synchronous clear of all counters
- pcwr  output  1  PC write enable
- ifidwr  output  1  IF/ID write enable
- ifidflush  output  1  IF/ID load NOP
- idexbubble  output  1  ID/EX load control-zero bubble
- pipewr  output  1  ID/EX, EX/MEM, MEM/WB write enable
- memerror  output  1  sticky memory timeout flag
- state  output  2  FSM state
- stallcount  output  CNTW  hazard stall cycles
- freezecount  output  CNTW  memory freeze cycles
- flushcount  output  CNTW  IF/ID flushes

Behaviour:
- A register match means: equal to ifidrs, or equal to ifidrt; source/destination 0 never matches.
- loaduse = idexmemrd && idexrt!=0 && (idexrt==ifidrs || (idexrt==ifidrt && !ifidmemwr)).
  - sw rt is excluded because the store path forwards from MEM/WB.
- brhaz = ifidbranch && any of:
  - idexregwr && idexregmuxout matches;
  - idexmemrd && idexrt matches;
  - exmemmemrd && exmemregmuxout matches.
  - A branch on a preceding lw therefore stalls 2 cycles, and on a preceding ALU op 1 cycle, by re-evaluation each cycle.
- stall = (loaduse || brhaz) && !freeze.
- freeze = memreq && !memready.
- FSM states: RUN=2'b00, MEMWAIT=2'b01, ERROR=2'b10.
  - RUN: freeze → MEMWAIT, waitcnt=1.
  - MEMWAIT:
    - memready or !memreq → RUN;
    - else if waitcnt==TIMEOUT-1 → ERROR, memerror←1;
    - else waitcnt++.
  - ERROR: held until rst.
- Output priority (control outputs combinational, same cycle):
  - ERROR: pcwr=ifidwr=pipewr=0, bubble=flush=0.
  - freeze: pcwr=ifidwr=pipewr=0, bubble=flush=0. The whole pipeline holds.
  - stall: pcwr=ifidwr=0, pipewr=1, idexbubble=1, ifidflush=0. branchtaken is ignored because the operands are not yet valid.
  - ifidbranch && branchtaken: pcwr=ifidwr=pipewr=1, ifidflush=1.
  - otherwise: pcwr=ifidwr=pipewr=1, bubble=flush=0.
- Counters:
  - +1 at each clk edge in a cycle where the condition holds: stall, freeze (any state except ERROR), ifidflush.
  - Saturate at all-ones.
  - cntclr has priority over increment.
- Reset (async, any time including mid-MEMWAIT):
  - state=RUN, waitcnt=0, memerror=0, all counters 0.
  - Control outputs follow the RUN rules above.

Test Plan:
1. lw $5 in EX (idexmemrd=1, idexrt=5), ID add rs=5 → pcwr=0, ifidwr=0, idexbubble=1 for exactly 1 cycle; stallcount=1.
2. Same lw, ID sw with rt=5, rs=3 → no stall: pcwr=1, idexbubble=0. Then rt=0 and idexrt=0 → no stall.
3. lw $7 in EX, ID beq rs=7, branchtaken=1 → 2 stall cycles with ifidflush=0, then one cycle ifidflush=1. Expect stallcount=2, flushcount=1. With an ALU producer instead: 1 stall cycle.
4. memreq=1, memready=0 for 5 cycles, then 1 → freeze for 5 cycles (all enables 0), state=01, then RUN; freezecount=5, memerror=0.
5. memready=0 held with TIMEOUT=16 → ERROR after 16 freeze cycles: memerror=1, state=10, pcwr=0 persists. Assert rst mid-ERROR → state=00, counters 0 immediately.
6. Preload stallcount to all-ones by sustained stall with CNTW=4 → holds at 15. cntclr with simultaneous stall → 0.
